// File: rtl/keypad_scanner_if.sv
// Keypad-side and controller-side signals of the 4x4 keypad scanner.
// master: the scanner itself; slave: the keypad model / downstream controller.
interface keypad_scanner_if;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] num;
  logic       pressed;
  logic       key_pulse;

  modport master (
    input  col,
    output row,
    output num,
    output pressed,
    output key_pulse
  );

  modport slave (
    output col,
    input  row,
    input  num,
    input  pressed,
    input  key_pulse
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 membrane keypad scanner with per-scan debounce, giving a stable code plus a level pressed flag.
// Optional auto-repeat of a held key is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 5,
  parameter int REPEAT_SCANS   = 125
) (
  input logic               clk,
  input logic               rd,
  keypad_scanner_if.master  kp
);

  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam int DEB_W  = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_SCANS - 1);
`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_SCANS + 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_SCANS - 1);
`endif

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CHECK      = 2'd1,
    HELD       = 2'd2,
    REPEAT_GAP = 2'd3
  } state_t;

  // Fixed key legend: 10 start, 11 cancel, 12 confirm.
  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'd1;   4'h1: code = 4'd2;   4'h2: code = 4'd3;   4'h3: code = 4'd10;
      4'h4: code = 4'd4;   4'h5: code = 4'd5;   4'h6: code = 4'd6;   4'h7: code = 4'd11;
      4'h8: code = 4'd7;   4'h9: code = 4'd8;   4'hA: code = 4'd9;   4'hB: code = 4'd12;
      4'hC: code = 4'd14;  4'hD: code = 4'd0;   4'hE: code = 4'd15;  4'hF: code = 4'd13;
      default: code = 4'd0;
    endcase
    return code;
  endfunction

  // Returns {hit, index} of the lowest asserted column.
  function automatic logic [2:0] lowest_col(input logic [3:0] low);
    logic [2:0] res;
    if (low[0])      res = 3'b100;
    else if (low[1]) res = 3'b101;
    else if (low[2]) res = 3'b110;
    else if (low[3]) res = 3'b111;
    else             res = 3'b000;
    return res;
  endfunction

  logic [3:0]        col_meta_r, col_sync_r;
  logic [SLOT_W-1:0] slot_r;
  logic [1:0]        row_idx_r;
  logic [3:0]        row_r;
  logic              hit_acc_r;
  logic [3:0]        code_acc_r;
  state_t            state_r;
  logic [3:0]        cand_r, num_r;
  logic [DEB_W-1:0]  cnt_r, rel_r;
  logic              pressed_r, key_pulse_r;
`ifdef KEYPAD_REPEAT_EN
  logic [REP_W-1:0]  rep_r;
`endif

  logic       tick_s, scan_end_s, scan_hit_s, match_s;
  logic [1:0] row_nxt_s;
  logic [2:0] col_sel_s;
  logic [3:0] scan_code_s;

  // Scan bookkeeping: slot tick, scan end, and this scan's result including the current row.
  always_comb begin
    tick_s      = (slot_r == SLOT_LAST);
    scan_end_s  = tick_s && (row_idx_r == 2'd3);
    row_nxt_s   = row_idx_r + 2'd1;
    col_sel_s   = lowest_col(~col_sync_r);
    scan_hit_s  = hit_acc_r | col_sel_s[2];
    if (hit_acc_r) begin
      scan_code_s = code_acc_r;
    end else begin
      scan_code_s = key_map(row_idx_r, col_sel_s[1:0]);
    end
    match_s     = scan_hit_s && (scan_code_s == num_r);
  end

  // Column synchroniser, slot counter and one-hot row drive.
  always_ff @(posedge clk or negedge rd) begin
    if (!rd) begin
      col_meta_r <= 4'b1111;
      col_sync_r <= 4'b1111;
      slot_r     <= {SLOT_W{1'b0}};
      row_idx_r  <= 2'd0;
      row_r      <= 4'b1110;
    end else begin
      col_meta_r <= kp.col;
      col_sync_r <= col_meta_r;
      if (tick_s) begin
        slot_r    <= {SLOT_W{1'b0}};
        row_idx_r <= row_nxt_s;
        row_r     <= 4'b1111 ^ (4'b0001 << row_nxt_s);
      end else begin
        slot_r    <= slot_r + SLOT_W'(1);
      end
    end
  end

  // Per-scan accumulation: the first row with a hit fixes the code (lowest row wins).
  always_ff @(posedge clk or negedge rd) begin
    if (!rd) begin
      hit_acc_r  <= 1'b0;
      code_acc_r <= 4'd0;
    end else if (scan_end_s) begin
      hit_acc_r  <= 1'b0;
      code_acc_r <= 4'd0;
    end else if (tick_s) begin
      hit_acc_r  <= scan_hit_s;
      code_acc_r <= scan_code_s;
    end else begin
      hit_acc_r  <= hit_acc_r;
      code_acc_r <= code_acc_r;
    end
  end

  // Debounce FSM, evaluated once per scan end; num only changes on acceptance.
  always_ff @(posedge clk or negedge rd) begin
    if (!rd) begin
      state_r     <= IDLE;
      cand_r      <= 4'd0;
      cnt_r       <= {DEB_W{1'b0}};
      rel_r       <= {DEB_W{1'b0}};
      num_r       <= 4'd0;
      pressed_r   <= 1'b0;
      key_pulse_r <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_r       <= {REP_W{1'b0}};
`endif
    end else begin
      key_pulse_r <= 1'b0;
      if (scan_end_s) begin
        case (state_r)
          IDLE: begin
            if (scan_hit_s) begin
              cand_r  <= scan_code_s;
              cnt_r   <= DEB_W'(1);
              state_r <= CHECK;
            end else begin
              cnt_r   <= {DEB_W{1'b0}};
            end
          end
          CHECK: begin
            if (scan_hit_s && (scan_code_s == cand_r)) begin
              if (cnt_r == DEB_LAST) begin
                num_r       <= cand_r;
                pressed_r   <= 1'b1;
                key_pulse_r <= 1'b1;
                cnt_r       <= {DEB_W{1'b0}};
                rel_r       <= {DEB_W{1'b0}};
                state_r     <= HELD;
              end else begin
                cnt_r       <= cnt_r + DEB_W'(1);
              end
            end else begin
              cnt_r   <= {DEB_W{1'b0}};
              state_r <= IDLE;
            end
          end
          HELD: begin
            if (match_s) begin
              rel_r <= {DEB_W{1'b0}};
`ifdef KEYPAD_REPEAT_EN
              if (rep_r == REP_LAST) begin
                rep_r     <= {REP_W{1'b0}};
                pressed_r <= 1'b0;
                state_r   <= REPEAT_GAP;
              end else begin
                rep_r     <= rep_r + REP_W'(1);
              end
`endif
            end else begin
`ifdef KEYPAD_REPEAT_EN
              rep_r <= {REP_W{1'b0}};
`endif
              if (rel_r == DEB_LAST) begin
                rel_r     <= {DEB_W{1'b0}};
                pressed_r <= 1'b0;
                state_r   <= IDLE;
              end else begin
                rel_r     <= rel_r + DEB_W'(1);
              end
            end
          end
`ifdef KEYPAD_REPEAT_EN
          // One scan with pressed low, then a fresh strobe for the same key.
          REPEAT_GAP: begin
            pressed_r   <= 1'b1;
            key_pulse_r <= 1'b1;
            state_r     <= HELD;
            if (match_s) begin
              rel_r <= {DEB_W{1'b0}};
            end else begin
              rel_r <= rel_r + DEB_W'(1);
            end
          end
`endif
          default: begin
            state_r   <= IDLE;
            pressed_r <= 1'b0;
            cnt_r     <= {DEB_W{1'b0}};
            rel_r     <= {DEB_W{1'b0}};
          end
        endcase
      end
    end
  end

  assign kp.row       = row_r;
  assign kp.num       = num_r;
  assign kp.pressed   = pressed_r;
  assign kp.key_pulse = key_pulse_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a switch-matrix keypad model (SCAN_DIV=4, DEBOUNCE_SCANS=3).
// The auto-repeat scenario is exercised when KEYPAD_REPEAT_EN is defined.
module tb_keypad_scanner;

  logic        clk;
  logic        rd;
  logic [15:0] keys;
  logic [3:0]  col_model;
  int          cyc;
  int          err_cnt;
  int          chk_cnt;

  keypad_scanner_if kif ();

  keypad_scanner #(
    .SCAN_DIV       (4),
    .DEBOUNCE_SCANS (3),
    .REPEAT_SCANS   (4)
  ) dut (
    .clk (clk),
    .rd  (rd),
    .kp  (kif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Passive matrix: a closed switch pulls its column low while its row is driven low.
  always_comb begin
    col_model = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !kif.row[r]) col_model[c] = 1'b0;
      end
    end
  end
  assign kif.col = col_model;

  always @(posedge clk or negedge rd) begin
    if (!rd) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_scan_end();
    do step(1); while (cyc % 16 != 0);
  endtask

  localparam logic [15:0] KEY_CONFIRM = 16'h0800;  // row2/col3 -> 12
  localparam logic [15:0] KEY_ONE     = 16'h0001;  // row0/col0 -> 1
  localparam logic [15:0] KEY_FIVE    = 16'h0020;  // row1/col1 -> 5

  initial begin
    int fell;
    int pulses;
    logic [3:0] exp_row;
    err_cnt = 0;
    chk_cnt = 0;
    keys    = 16'h0000;
    rd      = 1'b1;
    #2 rd   = 1'b0;
    #1;
    check_eq("rst_row", kif.row, 4'b1110);
    check_eq("rst_pressed", kif.pressed, 1'b0);
    check_eq("rst_num", kif.num, 4'd0);
    check_eq("rst_pulse", kif.key_pulse, 1'b0);
    step(3);
    @(negedge clk) rd = 1'b1;

    // Row walk: each row held for four cycles, wrapping after row3.
    for (int k = 0; k <= 16; k++) begin
      if (k > 0) step(1);
      exp_row = 4'b1111 ^ (4'b0001 << ((k / 4) % 4));
      check_eq($sformatf("row_walk_%0d", k), kif.row, exp_row);
    end

    // Steady press of confirm: accepted at the third matching scan end.
    wait_scan_end();
    keys = KEY_CONFIRM;
    step(47);
    check_eq("press_early", kif.pressed, 1'b0);
    step(1);
    check_eq("press_rise", kif.pressed, 1'b1);
    check_eq("press_num", kif.num, 4'd12);
    check_eq("press_pulse", kif.key_pulse, 1'b1);
    step(1);
    check_eq("pulse_width", kif.key_pulse, 1'b0);
    check_eq("press_hold", kif.pressed, 1'b1);

    // Two-scan release must not drop pressed.
    wait_scan_end();
    keys = 16'h0000;
    step(32);
    keys = KEY_CONFIRM;
    fell = 0;
    pulses = 0;
    for (int i = 0; i < 64; i++) begin
      step(1);
      if (!kif.pressed) fell++;
      if (kif.key_pulse) pulses++;
    end
    check_eq("short_release_fell", fell, 0);
    check_eq("short_release_pulse", pulses, 0);

    // Full release: pressed drops at the third empty scan end, num holds.
    wait_scan_end();
    keys = 16'h0000;
    step(47);
    check_eq("release_early", kif.pressed, 1'b1);
    step(1);
    check_eq("release_fall", kif.pressed, 1'b0);
    check_eq("release_num", kif.num, 4'd12);
    check_eq("release_pulse", kif.key_pulse, 1'b0);

    // Bounce every 10 cycles, then stable: three stable scans needed.
    wait_scan_end();
    fell = 0;
    for (int i = 0; i < 12; i++) begin
      keys = (i % 2 == 1) ? KEY_CONFIRM : 16'h0000;
      for (int j = 0; j < 10; j++) begin
        step(1);
        if (kif.pressed || kif.key_pulse) fell++;
      end
    end
    check_eq("bounce_quiet", fell, 0);
    keys = KEY_CONFIRM;
    step(39);
    check_eq("bounce_stable_early", kif.pressed, 1'b0);
    step(1);
    check_eq("bounce_stable_rise", kif.pressed, 1'b1);
    check_eq("bounce_stable_num", kif.num, 4'd12);

    wait_scan_end();
    keys = 16'h0000;
    step(48);
    check_eq("bounce_release", kif.pressed, 1'b0);

    // Two keys in different rows: the lowest row wins.
    wait_scan_end();
    keys = KEY_ONE | KEY_FIVE;
    step(48);
    check_eq("prio_rise", kif.pressed, 1'b1);
    check_eq("prio_num", kif.num, 4'd1);
    check_eq("prio_pulse", kif.key_pulse, 1'b1);

    // Asynchronous reset while held, mid-cycle, with no clock edge.
    step(5);
    #2 rd = 1'b0;
    #1;
    check_eq("arst_pressed", kif.pressed, 1'b0);
    check_eq("arst_row", kif.row, 4'b1110);
    check_eq("arst_num", kif.num, 4'd0);
    @(negedge clk) rd = 1'b1;
    keys = KEY_FIVE;
    step(47);
    check_eq("restart_early", kif.pressed, 1'b0);
    step(1);
    check_eq("restart_rise", kif.pressed, 1'b1);
    check_eq("restart_num", kif.num, 4'd5);

`ifdef KEYPAD_REPEAT_EN
    // Four matching HELD scans then one scan with pressed low and a fresh strobe.
    step(63);
    check_eq("rep_before", kif.pressed, 1'b1);
    step(1);
    check_eq("rep_drop", kif.pressed, 1'b0);
    step(15);
    check_eq("rep_gap_end", kif.pressed, 1'b0);
    check_eq("rep_gap_num", kif.num, 4'd5);
    step(1);
    check_eq("rep_reassert", kif.pressed, 1'b1);
    check_eq("rep_pulse", kif.key_pulse, 1'b1);
    check_eq("rep_num", kif.num, 4'd5);
    step(1);
    check_eq("rep_pulse_width", kif.key_pulse, 1'b0);
`else
    // Without auto-repeat a held key keeps pressed high with no further strobes.
    fell = 0;
    pulses = 0;
    for (int i = 0; i < 160; i++) begin
      step(1);
      if (!kif.pressed) fell++;
      if (kif.key_pulse) pulses++;
    end
    check_eq("hold_no_drop", fell, 0);
    check_eq("hold_no_pulse", pulses, 0);
    check_eq("hold_num", kif.num, 4'd5);
`endif

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans the 4x4 membrane keypad and debounces it, then presents one stable key code plus a level "pressed" flag.
- Sits directly upstream of the charging-station controller FSM, driving its num/pressed inputs.
- Hold times are sized so the controller's ~1 ms sampling tick always sees every press and every release.

Parameters:
- SCAN_DIV, 50000: clk cycles per row slot (1 ms at 50 MHz); must be >=3.
- DEBOUNCE_SCANS, 5: consecutive identical full scans needed to accept a press or a release.
- REPEAT_SCANS, 125: matching scans before an auto-repeat fires (only with KEYPAD_REPEAT_EN).

Ports:
- clk  in  1  system clock.
- rd  in  1  asynchronous active-low reset.
- col  in  4  keypad columns, active-low, pulled up, asynchronous to clk.
- row  out  4  keypad row drive, one-hot active-low.
- num  out  4  code of the accepted key; holds its last value after release.
- pressed  out  1  level, high while the accepted key is held.
- key_pulse  out  1  one-cycle strobe when pressed rises.

Behaviour:
- Reset (rd low, asynchronous): row=4'b1110, num=0, pressed=0, key_pulse=0, FSM=IDLE, all counters 0, col synchroniser=4'b1111.
- col passes through a 2-FF synchroniser.
- Slot counter runs 0..SCAN_DIV-1. Its last cycle is "tick".
- On tick:
  - Sample the synchronised col for the current row.
  - Advance the row index r: 0->1->2->3->0.
  - row = ~(1<<r).
- Four ticks form one scan. "Scan end" is the tick of r=3.
- Scan result:
  - hit = any sampled col bit low during the scan.
  - code = key at the lowest row, then the lowest col index (fixed priority, which masks ghosting).
- Key map (row0..3, col0..3):
  - row0: 1, 2, 3, 10
  - row1: 4, 5, 6, 11
  - row2: 7, 8, 9, 12
  - row3: 14, 0, 15, 13
  - 10 = start, 11 = cancel, 12 = confirm.
- FSM, evaluated only at scan end:
  - IDLE: if hit, cand=code, cnt=1, go to CHECK.
  - CHECK:
    - hit and code==cand: cnt++.
    - When cnt reaches DEBOUNCE_SCANS: num=cand, pressed=1, key_pulse=1 for that cycle, go to HELD.
    - No hit, or a different code: go to IDLE, cnt=0.
  - HELD:
    - hit and code==num: rel=0.
    - Otherwise: rel++.
    - When rel reaches DEBOUNCE_SCANS: pressed=0, go to IDLE.
    - A switch to a different key counts as a release. The new key then needs a full CHECK.
- Latency:
  - Press accepted at the DEBOUNCE_SCANS-th consistent scan end.
  - Minimum pressed-high width and minimum low gap are both DEBOUNCE_SCANS*4*SCAN_DIV cycles (20 ms by default).
- num changes only on acceptance, in the same cycle pressed rises. It is never altered while pressed=1.
- key_pulse never asserts outside the CHECK->HELD transition (or a repeat, see below).
- rd asserted mid-scan or while HELD: immediate return to the reset values. Scanning restarts at row0 after release of rd.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- With the macro:
  - In HELD, a repeat counter increments on each matching scan.
  - At REPEAT_SCANS it drops pressed for exactly one scan period (4*SCAN_DIV cycles).
  - It then reasserts pressed with a fresh key_pulse, clears the counter, and keeps num unchanged.
  - Any non-matching scan clears the repeat counter.
- Without the macro: pressed stays high for as long as the key is held. No repeat logic is synthesised.

Test Plan (SCAN_DIV=4, DEBOUNCE_SCANS=3, REPEAT_SCANS=4; scan = 16 cycles):
- Reset: hold rd low, then release -> row=1110, pressed=0, num=0, key_pulse=0. row then steps 1110, 1101, 1011, 0111, 4 cycles each, and repeats.
- Steady press: model row2/col3 closed -> pressed rises at the 3rd matching scan end, num=12, key_pulse high exactly 1 cycle.
- Bounce: the key toggles every 10 cycles for 120 cycles -> pressed stays 0. The key is then held stable -> pressed rises after 3 scans.
- Release: from HELD, open all keys -> pressed falls at the 3rd empty scan end and num stays 12. A release lasting only 2 scans -> pressed never falls.
- Priority and async reset:
  - row0/col0 and row1/col1 closed together -> num=1.
  - Pull rd low while HELD -> pressed=0 and row=1110 immediately, with no clock edge needed.
- KEYPAD_REPEAT_EN: hold key 5 -> after 4 matching scans in HELD, pressed is low for 16 cycles, then high with one key_pulse, and num stays 5 throughout.
